// File: rtl/buzzer_tone_scheduler_if.sv
// Event/select bundle between the quiz control logic and the buzzer tone scheduler.
interface buzzer_tone_scheduler_if;
  logic Evt_Answer;
  logic Evt_Correct;
  logic Evt_TimeOver;
  logic Clear;
  logic Buzzer_Answer;
  logic Buzzer_TimeOver;
  logic Answer_true;
  logic TimeOver_Stop;
  logic Busy;

  modport master (
    output Evt_Answer, Evt_Correct, Evt_TimeOver, Clear,
    input  Buzzer_Answer, Buzzer_TimeOver, Answer_true, TimeOver_Stop, Busy
  );

  modport slave (
    input  Evt_Answer, Evt_Correct, Evt_TimeOver, Clear,
    output Buzzer_Answer, Buzzer_TimeOver, Answer_true, TimeOver_Stop, Busy
  );
endinterface

// File: rtl/buzzer_tone_scheduler.sv
// Latches tone requests, plays them by fixed priority (TimeOver > Answer > Correct) with a trailing gap.
// Optional BUZZ_TRIPLE_BEEP_EN: a TimeOver request plays as three beeps of OVER_TICKS/3.
//
// state | meaning
// IDLE  | no tone; pick the highest-priority pending request
// PLAY  | winner's select held high for its duration
// GAP   | all selects low for GAP_TICKS
module buzzer_tone_scheduler #(
  parameter int TICK_DIV      = 50000,
  parameter int ANS_TICKS     = 200,
  parameter int CORRECT_TICKS = 300,
  parameter int OVER_TICKS    = 500,
  parameter int GAP_TICKS     = 50
) (
  input  logic CLK,
  input  logic RST,
  buzzer_tone_scheduler_if.slave bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
`ifdef BUZZ_TRIPLE_BEEP_EN
  localparam int OVR_RAW = OVER_TICKS / 3;
`else
  localparam int OVR_RAW = OVER_TICKS;
`endif
  localparam logic [15:0] ANS_LIM = 16'((ANS_TICKS < 1) ? 1 : ANS_TICKS);
  localparam logic [15:0] COR_LIM = 16'((CORRECT_TICKS < 1) ? 1 : CORRECT_TICKS);
  localparam logic [15:0] OVR_LIM = 16'((OVR_RAW < 1) ? 1 : OVR_RAW);
  localparam logic [15:0] GAP_LIM = 16'((GAP_TICKS < 1) ? 1 : GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
  typedef enum logic [1:0] {T_ANS, T_COR, T_OVR} tone_t;

  state_t           r_state, w_state_nxt;
  tone_t            r_tone, w_tone_nxt;
  logic [PRE_W-1:0] r_pre, w_pre_nxt;
  logic [15:0]      r_dur, w_dur_nxt;
  logic [15:0]      w_play_lim;
  logic             r_p_ans, r_p_cor, r_p_ovr;
  logic             w_p_ans_nxt, w_p_cor_nxt, w_p_ovr_nxt;
  logic             r_buz_ans, r_buz_ovr, r_ans_true, r_ovr_stop, r_busy;
  logic             w_tick_end;
  logic             w_play_nxt;
`ifdef BUZZ_TRIPLE_BEEP_EN
  logic [1:0]       r_beep, w_beep_nxt;
`endif

  assign w_tick_end = (r_pre == PRE_MAX);
  assign w_play_nxt = (w_state_nxt == S_PLAY);

  always_comb begin
    case (r_tone)
      T_COR:   w_play_lim = COR_LIM;
      T_OVR:   w_play_lim = OVR_LIM;
      default: w_play_lim = ANS_LIM;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tone_nxt  = r_tone;
    w_pre_nxt   = r_pre;
    w_dur_nxt   = r_dur;
    w_p_ans_nxt = r_p_ans | bus.Evt_Answer;
    w_p_cor_nxt = r_p_cor | bus.Evt_Correct;
    w_p_ovr_nxt = r_p_ovr | bus.Evt_TimeOver;
`ifdef BUZZ_TRIPLE_BEEP_EN
    w_beep_nxt  = r_beep;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_p_ovr || r_p_ans || r_p_cor) begin
          w_state_nxt = S_PLAY;
          w_pre_nxt   = '0;
          w_dur_nxt   = '0;
`ifdef BUZZ_TRIPLE_BEEP_EN
          w_beep_nxt  = 2'd0;
`endif
          // a same-type event arriving on the grant edge merges into this grant
          if (r_p_ovr) begin
            w_tone_nxt  = T_OVR;
            w_p_ovr_nxt = 1'b0;
          end else if (r_p_ans) begin
            w_tone_nxt  = T_ANS;
            w_p_ans_nxt = 1'b0;
          end else begin
            w_tone_nxt  = T_COR;
            w_p_cor_nxt = 1'b0;
          end
        end
      end
      S_PLAY: begin
        w_pre_nxt = w_tick_end ? '0 : r_pre + 1'b1;
        if (w_tick_end) begin
          if (r_dur == w_play_lim - 16'd1) begin
            w_state_nxt = S_GAP;
            w_dur_nxt   = '0;
          end else begin
            w_dur_nxt = r_dur + 16'd1;
          end
        end
      end
      S_GAP: begin
        w_pre_nxt = w_tick_end ? '0 : r_pre + 1'b1;
        if (w_tick_end) begin
          if (r_dur == GAP_LIM - 16'd1) begin
            w_dur_nxt = '0;
`ifdef BUZZ_TRIPLE_BEEP_EN
            if (r_tone == T_OVR && r_beep != 2'd2) begin
              w_state_nxt = S_PLAY;
              w_beep_nxt  = r_beep + 2'd1;
            end else begin
              w_state_nxt = S_IDLE;
            end
`else
            w_state_nxt = S_IDLE;
`endif
          end else begin
            w_dur_nxt = r_dur + 16'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.Clear) begin
      w_state_nxt = S_IDLE;
      w_pre_nxt   = '0;
      w_dur_nxt   = '0;
      w_p_ans_nxt = 1'b0;
      w_p_cor_nxt = 1'b0;
      w_p_ovr_nxt = 1'b0;
`ifdef BUZZ_TRIPLE_BEEP_EN
      w_beep_nxt  = 2'd0;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_tone     <= T_ANS;
      r_pre      <= '0;
      r_dur      <= '0;
      r_p_ans    <= 1'b0;
      r_p_cor    <= 1'b0;
      r_p_ovr    <= 1'b0;
      r_buz_ans  <= 1'b0;
      r_buz_ovr  <= 1'b0;
      r_ans_true <= 1'b0;
      r_ovr_stop <= 1'b1;
      r_busy     <= 1'b0;
`ifdef BUZZ_TRIPLE_BEEP_EN
      r_beep     <= 2'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_tone     <= w_tone_nxt;
      r_pre      <= w_pre_nxt;
      r_dur      <= w_dur_nxt;
      r_p_ans    <= w_p_ans_nxt;
      r_p_cor    <= w_p_cor_nxt;
      r_p_ovr    <= w_p_ovr_nxt;
      r_buz_ans  <= w_play_nxt && (w_tone_nxt == T_ANS);
      r_buz_ovr  <= w_play_nxt && (w_tone_nxt == T_OVR);
      r_ans_true <= w_play_nxt && (w_tone_nxt == T_COR);
      r_ovr_stop <= !(w_play_nxt && (w_tone_nxt == T_COR));
      r_busy     <= (w_state_nxt != S_IDLE);
`ifdef BUZZ_TRIPLE_BEEP_EN
      r_beep     <= w_beep_nxt;
`endif
    end
  end

  assign bus.Buzzer_Answer   = r_buz_ans;
  assign bus.Buzzer_TimeOver = r_buz_ovr;
  assign bus.Answer_true     = r_ans_true;
  assign bus.TimeOver_Stop   = r_ovr_stop;
  assign bus.Busy            = r_busy;

endmodule

// File: tb/tb_buzzer_tone_scheduler.sv
// Directed bench for buzzer_tone_scheduler with TICK_DIV=4, ANS=3, CORRECT=2, OVER=6, GAP=1.
module tb_buzzer_tone_scheduler;
  logic CLK;
  logic RST;
  int   n_total = 0;
  int   n_bad   = 0;

  buzzer_tone_scheduler_if bus();

  buzzer_tone_scheduler #(
    .TICK_DIV(4), .ANS_TICKS(3), .CORRECT_TICKS(2), .OVER_TICKS(6), .GAP_TICKS(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // {Busy, TimeOver_Stop, Answer_true, Buzzer_TimeOver, Buzzer_Answer}
  localparam logic [4:0] P_IDLE = 5'b01000;
  localparam logic [4:0] P_GAP  = 5'b11000;
  localparam logic [4:0] P_ANS  = 5'b11001;
  localparam logic [4:0] P_OVR  = 5'b11010;
  localparam logic [4:0] P_COR  = 5'b10100;

  logic [4:0] w_outs;
  assign w_outs = {bus.Busy, bus.TimeOver_Stop, bus.Answer_true, bus.Buzzer_TimeOver, bus.Buzzer_Answer};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // counts consecutive negedge samples equal to pat, stops at the first differing sample
  task automatic count_run(input logic [4:0] pat, input int cap, output int n);
    n = 0;
    while (w_outs == pat && n < cap) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic expect_run(input string tag, input logic [4:0] pat, input int exp_len);
    int n;
    count_run(pat, 200, n);
    check(tag, n, exp_len);
  endtask

  // ev = {Clear, Evt_TimeOver, Evt_Correct, Evt_Answer}, held for one cycle
  task automatic pulse(input logic [3:0] ev);
    bus.Clear        = ev[3];
    bus.Evt_TimeOver = ev[2];
    bus.Evt_Correct  = ev[1];
    bus.Evt_Answer   = ev[0];
    @(negedge CLK);
    bus.Clear        = 1'b0;
    bus.Evt_TimeOver = 1'b0;
    bus.Evt_Correct  = 1'b0;
    bus.Evt_Answer   = 1'b0;
  endtask

  initial begin
    int bad;
    int n;
    RST = 1'b1;
    bus.Clear = 1'b0; bus.Evt_Answer = 1'b0; bus.Evt_Correct = 1'b0; bus.Evt_TimeOver = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_outs", w_outs, P_IDLE);
    RST = 1'b0;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (w_outs !== P_IDLE) bad++;
      @(negedge CLK);
    end
    check("idle100", bad, 0);

    // single answer tone: one cycle of latency, 12 cycles on, 4 cycles gap
    pulse(4'b0001);
    check("ans_lat", w_outs, P_IDLE);
    @(negedge CLK);
    expect_run("ans_play", P_ANS, 12);
    expect_run("ans_gap", P_GAP, 4);
    check("ans_done", w_outs, P_IDLE);
    repeat (5) @(negedge CLK);

    // correct + timeover together: timeover first
    pulse(4'b0110);
    @(negedge CLK);
    expect_run("ovr_first", P_OVR, 24);
    expect_run("ovr_gap", P_GAP, 4);
    expect_run("ovr_idle", P_IDLE, 1);
    expect_run("cor_play", P_COR, 8);
    expect_run("cor_gap", P_GAP, 4);
    check("cor_done", w_outs, P_IDLE);
    repeat (5) @(negedge CLK);

    // answer + correct together: answer first
    pulse(4'b0011);
    @(negedge CLK);
    expect_run("pri_ans", P_ANS, 12);
    expect_run("pri_gap", P_GAP, 4);
    expect_run("pri_idle", P_IDLE, 1);
    expect_run("pri_cor", P_COR, 8);
    expect_run("pri_cgap", P_GAP, 4);
    repeat (5) @(negedge CLK);

    // three answer events during an answer tone merge into one more tone
    pulse(4'b0001);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      pulse(4'b0001);
      @(negedge CLK);
    end
    expect_run("mrg_rest", P_ANS, 6);
    expect_run("mrg_gap", P_GAP, 4);
    expect_run("mrg_idle", P_IDLE, 1);
    expect_run("mrg_again", P_ANS, 12);
    expect_run("mrg_gap2", P_GAP, 4);
    count_run(P_IDLE, 60, n);
    check("mrg_only1", n, 60);

    // Clear together with Evt_Correct mid-play
    pulse(4'b0001);
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    check("clr_pre", w_outs, P_ANS);
    pulse(4'b1010);
    check("clr_outs", w_outs, P_IDLE);
    count_run(P_IDLE, 60, n);
    check("clr_nocor", n, 60);

    // timeover requested during a gap is served after it
    pulse(4'b0001);
    @(negedge CLK);
    expect_run("gev_ans", P_ANS, 12);
    pulse(4'b0100);
    expect_run("gev_gap", P_GAP, 3);
    expect_run("gev_idle", P_IDLE, 1);
`ifdef BUZZ_TRIPLE_BEEP_EN
    expect_run("tb_beep1", P_OVR, 8);
    expect_run("tb_gap1", P_GAP, 4);
    expect_run("tb_beep2", P_OVR, 8);
    expect_run("tb_gap2", P_GAP, 4);
    expect_run("tb_beep3", P_OVR, 8);
    expect_run("tb_gap3", P_GAP, 4);
`else
    expect_run("gev_ovr", P_OVR, 24);
    expect_run("gev_ogap", P_GAP, 4);
`endif
    check("gev_done", w_outs, P_IDLE);
    repeat (5) @(negedge CLK);

    // asynchronous reset in the middle of a timeover tone
    pulse(4'b0100);
    @(negedge CLK);
`ifdef BUZZ_TRIPLE_BEEP_EN
    expect_run("rs_beep1", P_OVR, 8);
    expect_run("rs_gap1", P_GAP, 4);
    repeat (3) @(negedge CLK);
`else
    repeat (10) @(negedge CLK);
`endif
    check("rs_pre", w_outs, P_OVR);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async", w_outs, P_IDLE);
    @(negedge CLK);
    RST = 1'b0;
    count_run(P_IDLE, 30, n);
    check("rst_clean", n, 30);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
